line_memory: RTL

Dual-port, line-granular backing memory that serves the I-cache and D-cache miss/write-back traffic. Each port accepts a level-held read or write request for one 4-word (64-bit) line, completes it after a fixed latency, and signals completion with a one-cycle ready pulse. Read data is driven onto a shared tri-state line bus only during that pulse. The two ports run independent FSMs over one shared word array.

---
 rtl/line_memory.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/line_memory.sv
// Dual-port line memory: two independent request FSMs over one shared word array.
// Each port moves one 4-word line per request and pulses ready after a fixed latency.
module line_memory_port #(
    parameter int WORD_SIZE  = 16,
    parameter int FETCH_SIZE = 64,
    parameter int ADDR_BITS  = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  readM,
    input  logic                  writeM,
    input  logic [WORD_SIZE-1:0]  address,
    input  logic [FETCH_SIZE-1:0] memLine,
    output logic                  ready,
    output logic                  driveEn,
    output logic                  commitWr,
    output logic [ADDR_BITS-3:0]  lineAddr,
    output logic [FETCH_SIZE-1:0] lineReg
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state, stateNext;
    logic       armed;
    logic       opRead;
    logic [3:0] cnt;
    logic       accept;
    logic       lastBusy;

    // Word-select bits and bits above the decoded range play no part in the line index.
    logic unusedAddr;
    assign unusedAddr = ^{address[WORD_SIZE-1:ADDR_BITS], address[1:0]};

    assign accept   = (state == IDLE) && (readM || writeM) && armed;
    assign lastBusy = (state == BUSY) && (cnt == 4'(LATENCY - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = BUSY;
            BUSY:    if (lastBusy) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b1;
            cnt      <= '0;
            opRead   <= 1'b0;
            lineAddr <= '0;
            lineReg  <= '0;
        end else begin
            // A request must be seen low before the port will take another one.
            if (!readM && !writeM) armed <= 1'b1;
            else if (accept)       armed <= 1'b0;

            if (accept) begin
                cnt      <= 4'd1;
                opRead   <= readM;
                lineAddr <= address[ADDR_BITS-1:2];
            end else if (state == BUSY) begin
                cnt <= cnt + 4'd1;
            end

            // Snapshot uses pre-edge array contents, so a same-edge write is not seen.
            if (lastBusy && opRead) lineReg <= memLine;
        end
    end

    assign ready    = (state == DONE);
    assign driveEn  = ready && opRead;
    assign commitWr = ready && !opRead;
endmodule

module line_memory #(
    parameter int WORD_SIZE  = 16,
    parameter int FETCH_SIZE = 64,
    parameter int ADDR_BITS  = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_readM,
    input  logic                  i_writeM,
    input  logic [WORD_SIZE-1:0]  i_addressM,
    inout  wire  [FETCH_SIZE-1:0] i_dataM,
    output logic                  i_ready,
    input  logic                  d_readM,
    input  logic                  d_writeM,
    input  logic [WORD_SIZE-1:0]  d_addressM,
    inout  wire  [FETCH_SIZE-1:0] d_dataM,
    output logic                  d_ready
);
    localparam int NUM_PORTS = 2;   // index 0 = I-port, 1 = D-port
    localparam int WORDS     = FETCH_SIZE / WORD_SIZE;

    logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

    logic [NUM_PORTS-1:0]                 readM, writeM, ready, driveEn, commitWr;
    logic [NUM_PORTS-1:0][WORD_SIZE-1:0]  address;
    logic [NUM_PORTS-1:0][FETCH_SIZE-1:0] memLine, lineReg, busIn;
    logic [NUM_PORTS-1:0][ADDR_BITS-3:0]  lineAddr;

    assign readM   = {d_readM, i_readM};
    assign writeM  = {d_writeM, i_writeM};
    assign address = {d_addressM, i_addressM};
    assign busIn   = {d_dataM, i_dataM};
    assign i_ready = ready[0];
    assign d_ready = ready[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        for (genvar k = 0; k < WORDS; k++) begin : gWord
            assign memLine[p][k*WORD_SIZE +: WORD_SIZE] = mem[{lineAddr[p], 2'(k)}];
        end

        line_memory_port #(
            .WORD_SIZE(WORD_SIZE), .FETCH_SIZE(FETCH_SIZE),
            .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)
        ) uPort (
            .clk(clk), .reset_n(reset_n),
            .readM(readM[p]), .writeM(writeM[p]), .address(address[p]),
            .memLine(memLine[p]), .ready(ready[p]), .driveEn(driveEn[p]),
            .commitWr(commitWr[p]), .lineAddr(lineAddr[p]), .lineReg(lineReg[p])
        );
    end

    // D-port is written last so it wins a same-edge, same-line collision.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (commitWr[p]) begin
                for (int k = 0; k < WORDS; k++)
                    mem[{lineAddr[p], 2'(k)}] <= busIn[p][k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign i_dataM = driveEn[0] ? lineReg[0] : 'z;
    assign d_dataM = driveEn[1] ? lineReg[1] : 'z;
endmodule
